// File: rtl/evg_pkg.sv
// evg_pkg: shared constants and types for the event-link TX scheduler.
//   K28_5       comma character sent on the event lane
//   K_SEG_START K character opening a segmented-data frame on lane0
//   K_SEG_STOP  K character closing the data part of a segment frame
//   EV_BEACON   periodic beacon event code
//   seg_state_t segment-frame FSM states, in emission order
package evg_pkg;

  localparam logic [7:0] K28_5       = 8'hBC;
  localparam logic [7:0] K_SEG_START = 8'h5C;
  localparam logic [7:0] K_SEG_STOP  = 8'h3C;
  localparam logic [7:0] EV_BEACON   = 8'h7E;

  typedef enum logic [2:0] {
    SEG_IDLE,
    SEG_START,
    SEG_ADDR,
    SEG_DATA,
    SEG_STOP,
    SEG_CHK_H,
    SEG_CHK_L
  } seg_state_t;

endpackage

// File: rtl/evg_seg_sender.sv
// evg_seg_sender: segmented-data-buffer frame generator for lane0 odd words.
// Ports:
//   tx_clk, tx_rst   clock and synchronous active-high reset
//   aligned          link up; dropping it mid-frame aborts the frame
//   odd              current word is an odd word (frame bytes go out only there)
//   seg_start        request one frame (accepted only when idle and not busy)
//   seg_addr         segment address, captured with seg_start
//   seg_busy         frame in progress
//   seg_done         one-cycle pulse once the last checksum byte has left
//   seg_abort        one-cycle pulse when aligned drops during a frame
//   seg_rd_en        buffer read strobe, issued on the even word before each data slot
//   seg_rd_addr      buffer byte index
//   seg_rd_data      buffer byte, valid one cycle after seg_rd_en
//   lane0_byte       byte to place on lane0 if this is an odd word
//   lane0_k          lane0 K flag for that byte
module evg_seg_sender
  import evg_pkg::*;
#(
  parameter int SEG_BYTES = 16,
  localparam int AW = (SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  input  logic          aligned,
  input  logic          odd,
  input  logic          seg_start,
  input  logic [7:0]    seg_addr,
  output logic          seg_busy,
  output logic          seg_done,
  output logic          seg_abort,
  output logic          seg_rd_en,
  output logic [AW-1:0] seg_rd_addr,
  input  logic [7:0]    seg_rd_data,
  output logic [7:0]    lane0_byte,
  output logic          lane0_k
);

  localparam logic [AW-1:0] LAST_IDX = AW'(SEG_BYTES - 1);

  seg_state_t  state;
  logic [7:0]  addr_q;
  logic [15:0] sum_q;
  logic [15:0] chk;
  logic        fin_q;

  assign chk = 16'hFFFF - sum_q;

  // fin_q marks the cycle in which CHK_L sits on tx_data; seg_done and the
  // fall of seg_busy follow one cycle later, which also keeps a seg_start in
  // that in-between cycle from being accepted.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state       <= SEG_IDLE;
      addr_q      <= 8'h00;
      sum_q       <= 16'h0000;
      fin_q       <= 1'b0;
      seg_busy    <= 1'b0;
      seg_done    <= 1'b0;
      seg_abort   <= 1'b0;
      seg_rd_en   <= 1'b0;
      seg_rd_addr <= '0;
    end else if (!aligned) begin
      state     <= SEG_IDLE;
      fin_q     <= 1'b0;
      seg_busy  <= 1'b0;
      seg_done  <= 1'b0;
      seg_rd_en <= 1'b0;
      seg_abort <= seg_busy;
    end else begin
      seg_abort <= 1'b0;
      seg_done  <= fin_q;
      seg_rd_en <= 1'b0;
      fin_q     <= 1'b0;
      if (fin_q)
        seg_busy <= 1'b0;
      if (state == SEG_IDLE) begin
        if (seg_start && !seg_busy) begin
          state    <= SEG_START;
          seg_busy <= 1'b1;
          addr_q   <= seg_addr;
          sum_q    <= {8'h00, seg_addr};
        end
      end else if (odd) begin
        // Reads are launched on odd words so the strobe covers the following
        // even word and the byte lands in time for the next odd (DATA) word.
        case (state)
          SEG_START: state <= SEG_ADDR;
          SEG_ADDR: begin
            state       <= SEG_DATA;
            seg_rd_addr <= '0;
            seg_rd_en   <= 1'b1;
          end
          SEG_DATA: begin
            sum_q <= sum_q + {8'h00, seg_rd_data};
            if (seg_rd_addr == LAST_IDX) begin
              state <= SEG_STOP;
            end else begin
              seg_rd_addr <= seg_rd_addr + 1'b1;
              seg_rd_en   <= 1'b1;
            end
          end
          SEG_STOP:  state <= SEG_CHK_H;
          SEG_CHK_H: state <= SEG_CHK_L;
          SEG_CHK_L: begin
            state <= SEG_IDLE;
            fin_q <= 1'b1;
          end
          default:   state <= SEG_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    lane0_byte = 8'h00;
    lane0_k    = 1'b0;
    case (state)
      SEG_START: begin
        lane0_byte = K_SEG_START;
        lane0_k    = 1'b1;
      end
      SEG_ADDR:  lane0_byte = addr_q;
      SEG_DATA:  lane0_byte = seg_rd_data;
      SEG_STOP: begin
        lane0_byte = K_SEG_STOP;
        lane0_k    = 1'b1;
      end
      SEG_CHK_H: lane0_byte = chk[15:8];
      SEG_CHK_L: lane0_byte = chk[7:0];
      default:   ;
    endcase
  end

endmodule

// File: rtl/evg_tx_scheduler.sv
// evg_tx_scheduler: builds the 16-bit GTP TX word stream for the event link.
//   lane1 [15:8] event byte: comma > lowest-index requester > beacon > 0x00
//   lane0 [7:0]  dbus byte on even words, segment-frame byte on odd words
// Ports:
//   tx_clk, tx_rst          GTP TX user clock, synchronous active-high reset
//   aligned                 link up; low forces idle zeros and clears counters
//   ev_valid/ev_code        per-requester event request and 8-bit code
//   ev_ready                same-cycle grant; code taken when ev_valid & ev_ready
//   dbus                    distributed-bus byte, sampled on even words
//   seg_start/seg_addr      start a segment frame at the given address
//   seg_busy/done/abort     segment frame status
//   seg_rd_en/addr/data     segment buffer read port (one-cycle read latency)
//   tx_data/tx_charisk      registered TX word and per-lane K flags
module evg_tx_scheduler
  import evg_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int COMMA_PERIOD  = 4,
  parameter int BEACON_PERIOD = 1000,
  parameter int SEG_BYTES     = 16
) (
  input  logic                         tx_clk,
  input  logic                         tx_rst,
  input  logic                         aligned,
  input  logic [N_REQ-1:0]             ev_valid,
  input  logic [N_REQ*8-1:0]           ev_code,
  output logic [N_REQ-1:0]             ev_ready,
  input  logic [7:0]                   dbus,
  input  logic                         seg_start,
  input  logic [7:0]                   seg_addr,
  output logic                         seg_busy,
  output logic                         seg_done,
  output logic                         seg_abort,
  output logic                         seg_rd_en,
  output logic [$clog2(SEG_BYTES)-1:0] seg_rd_addr,
  input  logic [7:0]                   seg_rd_data,
  output logic [15:0]                  tx_data,
  output logic [1:0]                   tx_charisk
);

  // COMMA_PERIOD is a power of two, so the word counter only needs enough
  // bits to find the comma slot; w[0] still gives the even/odd phase.
  localparam int WW = $clog2(COMMA_PERIOD);
  localparam int BW = (BEACON_PERIOD > 1) ? $clog2(BEACON_PERIOD) : 1;

  logic [WW-1:0] w;
  logic [BW-1:0] bcnt;
  logic          beacon_pending;
  logic          comma_slot;
  logic          odd;
  logic [7:0]    ev_byte;
  logic          ev_k;
  logic          beacon_take;
  logic          found;
  logic [7:0]    seg_byte;
  logic          seg_k;

  assign comma_slot = (w == '0);
  assign odd        = w[0];

  evg_seg_sender #(
    .SEG_BYTES(SEG_BYTES)
  ) u_seg (
    .tx_clk     (tx_clk),
    .tx_rst     (tx_rst),
    .aligned    (aligned),
    .odd        (odd),
    .seg_start  (seg_start),
    .seg_addr   (seg_addr),
    .seg_busy   (seg_busy),
    .seg_done   (seg_done),
    .seg_abort  (seg_abort),
    .seg_rd_en  (seg_rd_en),
    .seg_rd_addr(seg_rd_addr),
    .seg_rd_data(seg_rd_data),
    .lane0_byte (seg_byte),
    .lane0_k    (seg_k)
  );

  // Event-lane arbiter. The grant is chosen from ev_valid alone so that a
  // requester's ready never depends on the code it presents.
  always_comb begin
    ev_ready    = '0;
    ev_byte     = 8'h00;
    ev_k        = 1'b0;
    beacon_take = 1'b0;
    found       = 1'b0;
    if (!tx_rst && aligned) begin
      if (comma_slot) begin
        ev_byte = K28_5;
        ev_k    = 1'b1;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (ev_valid[i] && !found) begin
            found       = 1'b1;
            ev_ready[i] = 1'b1;
            ev_byte     = ev_code[i*8 +: 8];
          end
        end
        if (!found && beacon_pending) begin
          ev_byte     = EV_BEACON;
          beacon_take = 1'b1;
        end
      end
    end
  end

  // Counters and the output word register. A beacon wrap in the same cycle
  // the pending beacon goes out leaves pending set: that wrap starts a new
  // period and still owes one beacon.
  always_ff @(posedge tx_clk) begin
    if (tx_rst || !aligned) begin
      w              <= '0;
      bcnt           <= '0;
      beacon_pending <= 1'b0;
      tx_data        <= 16'h0000;
      tx_charisk     <= 2'b00;
    end else begin
      w <= w + 1'b1;
      if (bcnt == BW'(BEACON_PERIOD - 1)) begin
        bcnt           <= '0;
        beacon_pending <= 1'b1;
      end else begin
        bcnt <= bcnt + 1'b1;
        if (beacon_take)
          beacon_pending <= 1'b0;
      end
      tx_data    <= {ev_byte, (odd ? seg_byte : dbus)};
      tx_charisk <= {ev_k, (odd ? seg_k : 1'b0)};
    end
  end

endmodule
